// File: rtl/mac_result_drain_pkg.sv
// Shared MAC constants and the beats-per-result decode used by the drain.
package mac_result_drain_pkg;

  localparam int MAC_ACC_WIDTH  = 32;
  localparam int MAC_CONF_WIDTH = 3;
  localparam int MAC_LANE_IDX_W = 2;

  localparam logic [1:0] MAC_SINGLE = 2'b00;
  localparam logic [1:0] MAC_DUAL   = 2'b01;
  localparam logic [1:0] MAC_QUAD   = 2'b10;

  // Accumulate results are always emitted whole; mode 2'b11 is raw C.
  function automatic logic [2:0] beats_per_entry(input logic [1:0] mode, input logic acc);
    logic [2:0] n;
    n = 3'd1;
    if (!acc) begin
      case (mode)
        MAC_DUAL: n = 3'd2;
        MAC_QUAD: n = 3'd4;
        default:  n = 3'd1;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/mac_drain_fifo.sv
// Synchronous FIFO holding captured MAC results; read data is the head entry, combinational.
module mac_drain_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) mem[wptr] <= din;
  end

  assign dout  = mem[rptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mac_result_drain.sv
// Tracks issued MAC ops, captures C one cycle after en, and serializes each result into lane beats.
module mac_result_drain
  import mac_result_drain_pkg::*;
#(
  parameter int ACC_W = MAC_ACC_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mac_en,
  input  logic [1:0]                mac_mode,
  input  logic                      mac_acc,
  input  logic [ACC_W-1:0]          mac_c,
  output logic                      issue_ok,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          out_data,
  output logic [MAC_LANE_IDX_W-1:0] out_lane,
  output logic                      out_last,
  output logic                      overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = ACC_W + 3;
  localparam int H  = ACC_W / 2;
  localparam int Q  = ACC_W / 4;

  logic                      inflight;
  logic [1:0]                mode_q;
  logic                      acc_q;
  logic [MAC_LANE_IDX_W-1:0] lane;

  logic [EW-1:0]    dout;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             beat_fire;
  logic             is_last;
  logic [2:0]       nbeats;
  logic [ACC_W-1:0] head_c;
  logic [ACC_W-1:0] lane_val;

  // An op still in the MAC pipeline holds a slot so its result always has room.
  assign issue_ok = ({1'b0, count} + (AW+2)'(inflight)) < (AW+2)'(DEPTH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight <= 1'b0;
      mode_q   <= '0;
      acc_q    <= 1'b0;
      overflow <= 1'b0;
      lane     <= '0;
    end else begin
      inflight <= mac_en & issue_ok;
      mode_q   <= mac_mode;
      acc_q    <= mac_acc;
      if (mac_en && !issue_ok) overflow <= 1'b1;
      if (beat_fire) lane <= is_last ? '0 : lane + 2'd1;
    end
  end

  assign push = inflight & ~full;

  mac_drain_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({mac_c, mode_q, acc_q}),
    .pop   (pop),
    .dout  (dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign head_c  = dout[EW-1:3];
  assign nbeats  = beats_per_entry(dout[2:1], dout[0]);
  assign is_last = (3'(lane) == nbeats - 3'd1);

  always_comb begin
    lane_val = '0;
    case (nbeats)
      3'd2: lane_val[H-1:0] = lane[0] ? head_c[2*H-1:H] : head_c[H-1:0];
      3'd4: begin
        case (lane)
          2'd0:    lane_val[Q-1:0] = head_c[Q-1:0];
          2'd1:    lane_val[Q-1:0] = head_c[2*Q-1:Q];
          2'd2:    lane_val[Q-1:0] = head_c[3*Q-1:2*Q];
          default: lane_val[Q-1:0] = head_c[4*Q-1:3*Q];
        endcase
      end
      default: lane_val = head_c;
    endcase
  end

  assign out_valid = ~empty;
  assign beat_fire = out_valid & out_ready;
  assign pop       = beat_fire & is_last;
  // Outputs are forced to zero when idle so the unreset FIFO storage never leaks out.
  assign out_data  = out_valid ? lane_val : '0;
  assign out_lane  = out_valid ? lane : '0;
  assign out_last  = out_valid & is_last;

endmodule
